// File: rtl/dec_scan_n.sv
// Registered N-to-2^N active-low decoder with active-low enable and autonomous scan mode.
// All outputs are registered and change one cycle after the inputs are sampled; there is no backpressure.
module dec_scan_n #(
  parameter int SEL_W     = 2,
  parameter int PRESCALE  = 50000,
  parameter int BLANK_CYC = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en_n,
  input  logic                  mode,
  input  logic [SEL_W-1:0]      sel,
  output logic [2**SEL_W-1:0]   out_n,
  output logic [SEL_W-1:0]      idx,
  output logic                  tick
);

  localparam int OUT_N  = 2**SEL_W;
  localparam int PERIOD = PRESCALE + BLANK_CYC;
  localparam int CNT_W  = (PERIOD > 1) ? $clog2(PERIOD) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PERIOD - 1);
  // One extra bit so PRESCALE itself is representable when there is no blanking.
  localparam logic [CNT_W:0]   PRE_LIM  = (CNT_W+1)'(PRESCALE);

  typedef enum logic [1:0] {IDLE, DIRECT, SCAN} state_t;

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   cnt, cnt_nxt;
  logic [OUT_N-1:0]   out_nxt;
  logic [SEL_W-1:0]   idx_nxt;
  logic               tick_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      out_n <= '1;
      idx   <= '0;
      tick  <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      out_n <= out_nxt;
      idx   <= idx_nxt;
      tick  <= tick_nxt;
    end
  end

  always_comb begin
    state_nxt = en_n ? IDLE : (mode ? SCAN : DIRECT);
    out_nxt   = '1;
    idx_nxt   = '0;
    tick_nxt  = 1'b0;
    cnt_nxt   = '0;
    case (state_nxt)
      DIRECT: begin
        out_nxt = ~(OUT_N'(1) << sel);
        idx_nxt = sel;
      end
      SCAN: begin
        // Entering from any other state always restarts the walk at line 0.
        if (state != SCAN) begin
          out_nxt = ~OUT_N'(1);
        end else if (cnt == CNT_LAST) begin
          idx_nxt  = idx + SEL_W'(1);
          tick_nxt = 1'b1;
          out_nxt  = ~(OUT_N'(1) << idx_nxt);
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
          idx_nxt = idx;
          out_nxt = ({1'b0, cnt_nxt} < PRE_LIM) ? ~(OUT_N'(1) << idx) : '1;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_dec_scan_n.sv
// Self-checking bench for dec_scan_n: a 2-bit instance with blanking and an 8-line instance without.
module tb_dec_scan_n;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       en_n = 1'b1, mode = 1'b0;
  logic [1:0] sel = '0;
  logic [3:0] out_n;
  logic [1:0] idx;
  logic       tick;

  logic       en_n_w = 1'b1, mode_w = 1'b0;
  logic [2:0] sel_w = '0;
  logic [7:0] out_n_w;
  logic [2:0] idx_w;
  logic       tick_w;

  always #5 clk = ~clk;

  dec_scan_n #(.SEL_W(2), .PRESCALE(4), .BLANK_CYC(1)) dut (
    .clk(clk), .rst_n(rst_n), .en_n(en_n), .mode(mode), .sel(sel),
    .out_n(out_n), .idx(idx), .tick(tick)
  );

  dec_scan_n #(.SEL_W(3), .PRESCALE(2), .BLANK_CYC(0)) dut_w (
    .clk(clk), .rst_n(rst_n), .en_n(en_n_w), .mode(mode_w), .sel(sel_w),
    .out_n(out_n_w), .idx(idx_w), .tick(tick_w)
  );

  typedef struct packed {
    logic       wide;
    logic [7:0] out;
    logic [2:0] idx;
    logic       tick;
  } exp_t;

  typedef struct {
    logic       e;
    logic       m;
    logic [1:0] s;
    logic [3:0] xo;
    logic [1:0] xi;
    logic       xt;
  } vec_t;

  exp_t sb[$];
  vec_t tbl[12];
  int   n_vec = 0;
  int   n_bad = 0;

  task automatic check_now(input string nm, input logic [7:0] ao, input logic [2:0] ai,
                           input logic at, input logic [7:0] xo, input logic [2:0] xi,
                           input logic xt);
    n_vec++;
    if (ao !== xo || ai !== xi || at !== xt) begin
      n_bad++;
      $display("FAIL %s: got out_n=%b idx=%0d tick=%b, want out_n=%b idx=%0d tick=%b",
               nm, ao, ai, at, xo, xi, xt);
    end
  endtask

  task automatic check_out(input string nm);
    exp_t x;
    if (sb.size() == 0) begin
      n_vec++;
      n_bad++;
      $display("FAIL %s: scoreboard empty", nm);
      return;
    end
    x = sb.pop_front();
    if (x.wide) check_now(nm, out_n_w, idx_w, tick_w, x.out, x.idx, x.tick);
    else        check_now(nm, {4'h0, out_n}, {1'b0, idx}, tick, x.out, x.idx, x.tick);
  endtask

  task automatic step(input logic e, input logic m, input logic [1:0] s, input logic [3:0] xo,
                      input logic [1:0] xi, input logic xt, input string nm);
    @(negedge clk);
    en_n = e; mode = m; sel = s;
    sb.push_back('{wide: 1'b0, out: {4'h0, xo}, idx: {1'b0, xi}, tick: xt});
    @(posedge clk);
    #1;
    check_out(nm);
  endtask

  task automatic step_w(input logic e, input logic m, input logic [2:0] s, input logic [7:0] xo,
                        input logic [2:0] xi, input logic xt, input string nm);
    @(negedge clk);
    en_n_w = e; mode_w = m; sel_w = s;
    sb.push_back('{wide: 1'b1, out: xo, idx: xi, tick: xt});
    @(posedge clk);
    #1;
    check_out(nm);
  endtask

  // k counts cycles since scan entry: 4 lit cycles then 1 blank per line.
  task automatic scan_run(input int k0, input int k1, input string tag);
    for (int k = k0; k <= k1; k++) begin
      int line;
      int ph;
      logic [3:0] xo;
      line = (k / 5) % 4;
      ph   = k % 5;
      xo   = (ph < 4) ? (4'hF ^ (4'h1 << line)) : 4'hF;
      step(1'b0, 1'b1, 2'(k), xo, 2'(line), (ph == 0 && k > 0), $sformatf("%s k=%0d", tag, k));
    end
  endtask

  initial begin
    tbl[0]  = '{1'b1, 1'b0, 2'd0, 4'b1111, 2'd0, 1'b0};
    tbl[1]  = '{1'b1, 1'b1, 2'd3, 4'b1111, 2'd0, 1'b0};
    tbl[2]  = '{1'b1, 1'b0, 2'd2, 4'b1111, 2'd0, 1'b0};
    tbl[3]  = '{1'b0, 1'b0, 2'd0, 4'b1110, 2'd0, 1'b0};
    tbl[4]  = '{1'b0, 1'b0, 2'd1, 4'b1101, 2'd1, 1'b0};
    tbl[5]  = '{1'b0, 1'b0, 2'd2, 4'b1011, 2'd2, 1'b0};
    tbl[6]  = '{1'b0, 1'b0, 2'd3, 4'b0111, 2'd3, 1'b0};
    tbl[7]  = '{1'b0, 1'b1, 2'd3, 4'b1110, 2'd0, 1'b0};
    tbl[8]  = '{1'b0, 1'b0, 2'd2, 4'b1011, 2'd2, 1'b0};
    tbl[9]  = '{1'b0, 1'b1, 2'd1, 4'b1110, 2'd0, 1'b0};
    tbl[10] = '{1'b0, 1'b0, 2'd3, 4'b0111, 2'd3, 1'b0};
    tbl[11] = '{1'b1, 1'b1, 2'd0, 4'b1111, 2'd0, 1'b0};

    #2 rst_n = 1'b0;
    #1;
    check_now("reset narrow", {4'h0, out_n}, {1'b0, idx}, tick, 8'h0F, 3'd0, 1'b0);
    check_now("reset wide", out_n_w, idx_w, tick_w, 8'hFF, 3'd0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    // Idle gating, direct decode, mode toggling.
    for (int i = 0; i < 12; i++)
      step(tbl[i].e, tbl[i].m, tbl[i].s, tbl[i].xo, tbl[i].xi, tbl[i].xt,
           $sformatf("table[%0d]", i));

    // Full frame with blanking, ending on the wrapped line 0.
    scan_run(0, 20, "frame");

    // Single-cycle disable at idx 2.
    step(1'b1, 1'b1, 2'd0, 4'b1111, 2'd0, 1'b0, "park idle");
    scan_run(0, 10, "to idx2");
    step(1'b1, 1'b1, 2'd0, 4'b1111, 2'd0, 1'b0, "en_n pulse");
    scan_run(0, 10, "restart");

    // Asynchronous reset between edges at idx 2.
    #1 rst_n = 1'b0;
    #1;
    check_now("async reset", {4'h0, out_n}, {1'b0, idx}, tick, 8'h0F, 3'd0, 1'b0);
    #1 rst_n = 1'b1;
    scan_run(0, 15, "after reset");

    // Mode switch at idx 3, then back into scan.
    step(1'b0, 1'b0, 2'd1, 4'b1101, 2'd1, 1'b0, "to direct");
    scan_run(0, 5, "rescan");
    step(1'b1, 1'b0, 2'd0, 4'b1111, 2'd0, 1'b0, "narrow off");

    // Eight-line walk, 2 cycles per line, wrap 7 -> 0 with tick.
    for (int k = 0; k <= 17; k++) begin
      int line;
      line = (k / 2) % 8;
      step_w(1'b0, 1'b1, 3'(k), 8'hFF ^ (8'h01 << line), 3'(line), (k % 2 == 0 && k > 0),
             $sformatf("wide k=%0d", k));
    end
    step_w(1'b0, 1'b0, 3'd5, 8'b1101_1111, 3'd5, 1'b0, "wide direct");
    step_w(1'b1, 1'b1, 3'd0, 8'hFF, 3'd0, 1'b0, "wide off");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/dec_scan_n.md
# dec_scan_n

Parametrised, registered N-to-2^N active-low decoder with an active-low enable and an autonomous scan mode. In direct mode it decodes a select bus to one active-low output line. In scan mode it cycles through every output line itself, with a programmable dwell time and blanking gap. It sits between the control logic and multiplexed active-low loads (digit anodes, row strobes, chip selects) and replaces hand-written fixed-width combinational decoders.

## Interface
- `SEL_W`, default 2: select width, legal range 1..5. Output count `OUT_N = 2**SEL_W` (localparam).
- `PRESCALE`, default 50000: cycles each line stays active in scan mode; must be ≥1.
- `BLANK_CYC`, default 0: cycles with all lines inactive between scan steps; must be ≥0.
- `clk` — input, 1 bit: single clock; all logic is rising-edge triggered.
- `rst_n` — input, 1 bit: asynchronous, active-low reset.
- `en_n` — input, 1 bit: active-low enable; high forces all outputs inactive.
- `mode` — input, 1 bit: 0 = direct decode, 1 = scan.
- `sel` — input, SEL_W bits: line index in direct mode; ignored in scan mode.
- `out_n` — output, OUT_N bits: registered, one-cold decoded outputs; `1` means inactive.
- `idx` — output, SEL_W bits: registered index of the line currently selected.
- `tick` — output, 1 bit: one-cycle pulse when scan advances to a new index.

## Operation
- State machine, registered, with three states:
  - IDLE (entered on reset or when `en_n=1`).
  - DIRECT (`en_n=0`, `mode=0`).
  - SCAN (`en_n=0`, `mode=1`).
- State transitions: the next state is chosen each cycle only from the sampled `en_n`/`mode`. `en_n=1` has priority over `mode`.
- IDLE behaviour:
  - `out_n` = all ones, `idx`=0, `tick`=0.
  - Scan counter `cnt` cleared to 0.
- DIRECT behaviour:
  - `out_n = ~(1 << sel)`, `idx = sel`, `tick`=0, `cnt`=0.
- Entering SCAN from IDLE or DIRECT:
  - `idx`=0, `cnt`=0, `out_n = ~1`, `tick`=0.
- Within SCAN:
  - `cnt` runs 0..PRESCALE+BLANK_CYC−1.
  - While `cnt < PRESCALE`: `out_n = ~(1 << idx)`.
  - While `cnt ≥ PRESCALE`: `out_n` = all ones (blanking).
- Scan advance:
  - When `cnt == PRESCALE+BLANK_CYC−1`, the next cycle has `cnt`=0, `idx = (idx+1) mod OUT_N`, `tick`=1.
  - Wrap from OUT_N−1 to 0 is silent: no special flag.
- Leaving SCAN to DIRECT: next cycle follows `sel` immediately. Scan position is discarded.
- Leaving SCAN to IDLE: next cycle all outputs are inactive and `idx`/`cnt` return to 0. Re-entering SCAN always restarts at index 0.
- `cnt` width is `$clog2(PRESCALE+BLANK_CYC)`, minimum 1 bit. No overflow is possible.
- At most one bit of `out_n` is ever 0. No glitch-free decoding of `sel` is required beyond registering.

## Timing
- Reset (`rst_n=0`, asynchronous):
  - `out_n` = all ones, `idx`=0, `tick`=0, `cnt`=0, state IDLE.
  - Deassertion is sampled on the next rising edge.
- Direct-mode latency: 1 cycle from `sel`/`en_n`/`mode` sample to `out_n`.
- Scan period per line is PRESCALE+BLANK_CYC cycles. Full frame is OUT_N×(PRESCALE+BLANK_CYC) cycles.
- `tick` is high exactly one cycle, in the same cycle the new `idx` and its active `out_n` appear.
- Reset mid-scan: outputs go inactive immediately (asynchronous). After release, the next scan starts at index 0.
- `en_n` high for a single cycle mid-scan: one cycle in IDLE, then scan restarts at index 0.
- `mode` toggling every cycle:
  - Alternates DIRECT/SCAN-entry.
  - SCAN-entry cycles show `out_n = ~1`, `tick`=0.
- `PRESCALE=1`, `BLANK_CYC=0`: `idx` advances every cycle and `tick` stays high continuously while in SCAN, except the entry cycle.

## Test plan
1. Reset and enable gating: SEL_W=2, `rst_n=0` then release with `en_n=1` → `out_n=4'b1111`, `idx=0`, `tick=0` indefinitely.
2. Direct decode: SEL_W=2, `en_n=0`, `mode=0`, `sel` = 0,1,2,3 on consecutive cycles → `out_n` = 1110, 1101, 1011, 0111, each one cycle later; `idx` tracks `sel`.
3. Scan with blanking: PRESCALE=4, BLANK_CYC=1, `mode=1`, `en_n=0`:
   - Expected `out_n`: 1110 for 4 cycles, 1111 for 1 cycle, 1101 for 4, 1111 for 1, 1011 for 4, 1111 for 1, 0111 for 4, 1111 for 1, then 1110 again.
   - `tick` high exactly on the first cycle of 1101, 1011, 0111 and the wrapped 1110.
4. Wide parameter: SEL_W=3, PRESCALE=2, BLANK_CYC=0 → one-cold walk across 8 lines, each line 2 cycles, frame 16 cycles, `idx` wraps 7→0 with `tick`=1.
5. Mid-operation interruption: during scan at `idx=2`:
   - Pulse `en_n=1` for one cycle → one all-ones cycle, then `out_n=1110`, `idx=0`.
   - Repeat at `idx=2` with an asynchronous `rst_n` pulse between clock edges → `out_n` goes to 1111 before the next edge.
6. Mode switch: scanning at `idx=3`, set `mode=0` with `sel=1` → next cycle `out_n=1101`, `idx=1`, `tick=0`. Set `mode=1` again → restart at `1110`.
